// File: rtl/if_id_buffer.sv
// IF/ID instruction buffer: small FIFO of {instruction, pc} between fetch and decode,
// exposing the head entry with pre-decoded RV32I register fields and an illegal-opcode flag.
module if_id_buffer #(
  parameter int PC_WIDTH  = 4,
  parameter int INS_WIDTH = 32,
  parameter int DEPTH     = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INS_WIDTH-1:0]     in_ins,
  input  logic [PC_WIDTH-1:0]      in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INS_WIDTH-1:0]     out_ins,
  output logic [PC_WIDTH-1:0]      out_pc,
  output logic [6:0]               out_opcode,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [INS_WIDTH-1:0] ins;
    logic [PC_WIDTH-1:0]  pc;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, legal;

  // Handshake flags come only from the registered count, so no in->out combinational path.
  assign in_ready  = (count != (AW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  // Storage is never cleared; occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    if (push && !flush && !reset) mem[wr_ptr] <= '{ins: in_ins, pc: in_pc};
  end

  assign out_ins    = out_valid ? mem[rd_ptr].ins : '0;
  assign out_pc     = out_valid ? mem[rd_ptr].pc  : '0;
  assign out_opcode = out_ins[6:0];
  assign out_rd     = out_ins[11:7];
  assign out_rs1    = out_ins[19:15];
  assign out_rs2    = out_ins[24:20];

  always_comb begin
    legal = 1'b0;
    case (out_opcode)
      7'h03, 7'h13, 7'h17, 7'h23, 7'h33,
      7'h37, 7'h63, 7'h67, 7'h6F, 7'h73: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
  end

  assign out_illegal = out_valid && !legal;
endmodule

// File: tb/tb_if_id_buffer.sv
// Table-driven bench for if_id_buffer with a queue scoreboard of accepted {ins, pc} entries.
module tb_if_id_buffer;
  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_ins, out_ins;
  logic [3:0]  in_pc, out_pc;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [1:0]  count;

  int total = 0;
  int bad   = 0;

  logic [35:0] sb[$];

  typedef struct {
    logic        rst, f, iv, ordy;
    logic [31:0] ins;
    logic [3:0]  pc;
    int          cnt;
    logic        fchk, ill;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
  } vec_t;

  vec_t vt[$];

  if_id_buffer #(.PC_WIDTH(4), .INS_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_ins(out_ins), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_illegal(out_illegal), .count(count)
  );

  always #5 clock = ~clock;

  function automatic logic legal(input logic [6:0] op);
    case (op)
      7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic vec_t mk(input logic rst, f, iv, input logic [31:0] ins,
                              input logic [3:0] pc, input logic ordy, input int cnt);
    vec_t v;
    v.rst = rst; v.f = f; v.iv = iv; v.ins = ins; v.pc = pc; v.ordy = ordy; v.cnt = cnt;
    v.fchk = 1'b0; v.ill = 1'b0; v.op = '0; v.rd = '0; v.rs1 = '0; v.rs2 = '0;
    return v;
  endfunction

  function automatic vec_t mkf(input vec_t b, input logic [6:0] op, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic ill);
    vec_t v = b;
    v.fchk = 1'b1; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle after the falling edge, compare before the rising edge, then update the model.
  task automatic cyc(input vec_t v);
    logic [35:0] h;
    logic        ev;
    int          n;
    reset = v.rst; flush = v.f; in_valid = v.iv; in_ins = v.ins; in_pc = v.pc; out_ready = v.ordy;
    #1;
    ev = (sb.size() != 0);
    h  = ev ? sb[0] : 36'h0;
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("in_ready", 32'(in_ready), 32'(sb.size() != DEPTH));
    chk("count_model", 32'(count), 32'(sb.size()));
    if (v.cnt >= 0) chk("count_vec", 32'(count), 32'(v.cnt));
    chk("out_ins", out_ins, h[35:4]);
    chk("out_pc", 32'(out_pc), 32'(h[3:0]));
    chk("out_opcode", 32'(out_opcode), 32'(h[10:4]));
    chk("out_rd", 32'(out_rd), 32'(h[15:11]));
    chk("out_rs1", 32'(out_rs1), 32'(h[23:19]));
    chk("out_rs2", 32'(out_rs2), 32'(h[28:24]));
    chk("out_illegal", 32'(out_illegal), 32'(ev && !legal(h[10:4])));
    if (v.fchk) begin
      chk("fld_opcode", 32'(out_opcode), 32'(v.op));
      chk("fld_rd", 32'(out_rd), 32'(v.rd));
      chk("fld_rs1", 32'(out_rs1), 32'(v.rs1));
      chk("fld_rs2", 32'(out_rs2), 32'(v.rs2));
      chk("fld_illegal", 32'(out_illegal), 32'(v.ill));
    end
    @(posedge clock);
    if (v.rst || v.f) sb.delete();
    else begin
      n = sb.size();
      if (n != 0 && v.ordy) void'(sb.pop_front());
      if (v.iv && n < DEPTH) sb.push_back({v.ins, v.pc});
    end
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ins = '0; in_pc = '0; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    sb.delete();

    // idle after reset
    for (int i = 0; i < 3; i++) vt.push_back(mk(0, 0, 0, 32'h0, 4'h0, 0, 0));
    // streaming
    vt.push_back(mk(0, 0, 1, 32'h00000013, 4'h0, 1, 0));
    vt.push_back(mkf(mk(0, 0, 1, 32'h00A00093, 4'h4, 1, 1), 7'h13, 5'd0, 5'd0, 5'd0, 0));
    vt.push_back(mkf(mk(0, 0, 1, 32'h002081B3, 4'h8, 1, 1), 7'h13, 5'd1, 5'd0, 5'd10, 0));
    vt.push_back(mkf(mk(0, 0, 0, 32'h0, 4'h0, 1, 1), 7'h33, 5'd3, 5'd1, 5'd2, 0));
    vt.push_back(mk(0, 0, 0, 32'h0, 4'h0, 1, 0));
    // backpressure: third word held by fetch until space frees
    vt.push_back(mk(0, 0, 1, 32'h11100013, 4'h1, 0, 0));
    vt.push_back(mk(0, 0, 1, 32'h22200013, 4'h2, 0, 1));
    vt.push_back(mk(0, 0, 1, 32'h33300013, 4'h3, 0, 2));
    vt.push_back(mk(0, 0, 1, 32'h33300013, 4'h3, 1, 2));
    vt.push_back(mk(0, 0, 1, 32'h33300013, 4'h3, 1, 1));
    vt.push_back(mk(0, 0, 0, 32'h0, 4'h0, 1, 1));
    vt.push_back(mk(0, 0, 0, 32'h0, 4'h0, 1, 0));
    // simultaneous push/pop at count=1 across pointer wrap
    for (int i = 0; i < 8; i++)
      vt.push_back(mk(0, 0, 1, 32'h00000033 | (32'(i + 1) << 7), 4'(i), 1, (i == 0) ? 0 : 1));
    vt.push_back(mk(0, 0, 0, 32'h0, 4'h0, 1, 1));
    vt.push_back(mk(0, 0, 0, 32'h0, 4'h0, 1, 0));
    // flush at count=2 while pushing and popping
    vt.push_back(mk(0, 0, 1, 32'hAAA00013, 4'hA, 0, 0));
    vt.push_back(mk(0, 0, 1, 32'hBBB00013, 4'hB, 0, 1));
    vt.push_back(mk(0, 1, 1, 32'hCCC00013, 4'hC, 1, 2));
    vt.push_back(mk(0, 0, 1, 32'hDDD00013, 4'hD, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h0, 4'h0, 1, 1));
    vt.push_back(mk(0, 0, 0, 32'h0, 4'h0, 1, 0));
    // illegal vs legal opcode
    vt.push_back(mk(0, 0, 1, 32'h0000007F, 4'h5, 0, 0));
    vt.push_back(mkf(mk(0, 0, 0, 32'h0, 4'h0, 1, 1), 7'h7F, 5'd0, 5'd0, 5'd0, 1));
    vt.push_back(mk(0, 0, 1, 32'h00000063, 4'h6, 0, 0));
    vt.push_back(mkf(mk(0, 0, 0, 32'h0, 4'h0, 1, 1), 7'h63, 5'd0, 5'd0, 5'd0, 0));
    vt.push_back(mk(0, 0, 0, 32'h0, 4'h0, 1, 0));

    foreach (vt[i]) cyc(vt[i]);

    // mid-stream reset with a concurrent push, then a normal push right after
    cyc(mk(0, 0, 1, 32'h01000013, 4'h1, 0, 0));
    cyc(mk(0, 0, 1, 32'h02000013, 4'h2, 0, 1));
    cyc(mk(1, 0, 1, 32'h03000013, 4'h3, 1, 2));
    cyc(mk(0, 0, 1, 32'h04000037, 4'h4, 0, 0));
    cyc(mkf(mk(0, 0, 0, 32'h0, 4'h0, 1, 1), 7'h37, 5'd0, 5'd0, 5'd0, 0));
    cyc(mk(0, 0, 0, 32'h0, 4'h0, 0, 0));

    if (sb.size() != 0) chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
